// File: rtl/csr_trap_ctrl_if.sv
// CSR set/clear bus between the trap sequencer and the machine-mode CSR field modules.
// The sequencer drives the master side; the field modules answer on the slave side.
interface csr_trap_ctrl_if;
  logic        en_o;
  logic [11:0] addr_o;
  logic [31:0] set_o;
  logic [31:0] clear_o;
  logic        ack_i;
  logic [31:0] mstatus_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;

  modport master (
    output en_o, addr_o, set_o, clear_o,
    input  ack_i, mstatus_i, mtvec_i, mepc_i
  );

  modport slave (
    input  en_o, addr_o, set_o, clear_o,
    output ack_i, mstatus_i, mtvec_i, mepc_i
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer: serialises trap entry and mret onto the CSR set/clear
// bus and arbitrates single-cycle pipeline CSR accesses onto the same bus.
module csr_trap_ctrl (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   trap_req_i,
  input  logic [31:0]            trap_pc_i,
  input  logic [31:0]            trap_cause_i,
  input  logic [31:0]            trap_tval_i,
  input  logic                   mret_i,
  input  logic                   csr_req_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [31:0]            csr_set_i,
  input  logic [31:0]            csr_clear_i,
  output logic                   csr_done_o,
  output logic                   csr_err_o,
  csr_trap_ctrl_if.master        bus,
  output logic                   trap_ack_o,
  output logic                   mret_ack_o,
  output logic                   busy_o,
  output logic                   redirect_valid_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   fault_o
);

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] T_EPC    = 3'd1;
  localparam logic [2:0] T_CAUSE  = 3'd2;
  localparam logic [2:0] T_TVAL   = 3'd3;
  localparam logic [2:0] T_STATUS = 3'd4;
  localparam logic [2:0] T_REDIR  = 3'd5;
  localparam logic [2:0] M_STATUS = 3'd6;
  localparam logic [2:0] M_REDIR  = 3'd7;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc_q, cause_q, tval_q;
  logic        mie_q;
  logic        idle_live, trap_acc, mret_acc, csr_acc;
  logic        unused_bits;

  // Gating with rst_i keeps every output at 0 while reset is held, even in IDLE.
  assign idle_live = (state == IDLE) && rst_i;
  assign trap_acc  = idle_live && trap_req_i;
  assign mret_acc  = idle_live && !trap_req_i && mret_i;
  assign csr_acc   = idle_live && !trap_req_i && !mret_i && csr_req_i;

  assign unused_bits = ^{trap_pc_i[1:0], bus.mstatus_i[31:8], bus.mstatus_i[6:4],
                         bus.mstatus_i[2:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trap_acc)      state_nxt = T_EPC;
        else if (mret_acc) state_nxt = M_STATUS;
      end
      T_EPC:    state_nxt = T_CAUSE;
      T_CAUSE:  state_nxt = T_TVAL;
      T_TVAL:   state_nxt = T_STATUS;
      T_STATUS: state_nxt = T_REDIR;
      T_REDIR:  state_nxt = IDLE;
      M_STATUS: state_nxt = M_REDIR;
      M_REDIR:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      mie_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (trap_acc) begin
        pc_q    <= {trap_pc_i[31:2], 2'b00};
        cause_q <= trap_cause_i;
        tval_q  <= trap_tval_i;
        mie_q   <= bus.mstatus_i[3];
      end
    end
  end

  always_comb begin
    bus.en_o         = 1'b0;
    bus.addr_o       = '0;
    bus.set_o        = '0;
    bus.clear_o      = '0;
    trap_ack_o       = 1'b0;
    mret_ack_o       = 1'b0;
    csr_done_o       = 1'b0;
    csr_err_o        = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    fault_o          = 1'b0;
    case (state)
      IDLE: begin
        if (trap_acc) begin
          trap_ack_o = 1'b1;
        end else if (mret_acc) begin
          mret_ack_o = 1'b1;
        end else if (csr_acc) begin
          bus.en_o    = 1'b1;
          bus.addr_o  = csr_addr_i;
          bus.set_o   = csr_set_i;
          bus.clear_o = csr_clear_i;
          csr_done_o  = 1'b1;
          csr_err_o   = !bus.ack_i;
        end
      end
      T_EPC: begin
        bus.en_o    = 1'b1;
        bus.addr_o  = MEPC;
        bus.set_o   = pc_q;
        bus.clear_o = ~pc_q;
      end
      T_CAUSE: begin
        bus.en_o    = 1'b1;
        bus.addr_o  = MCAUSE;
        bus.set_o   = cause_q;
        bus.clear_o = ~cause_q;
      end
      T_TVAL: begin
        bus.en_o    = 1'b1;
        bus.addr_o  = MTVAL;
        bus.set_o   = tval_q;
        bus.clear_o = ~tval_q;
      end
      T_STATUS: begin
        // MPIE <- MIE, MPP <- M, MIE <- 0; every other field left untouched.
        bus.en_o    = 1'b1;
        bus.addr_o  = MSTATUS;
        bus.set_o   = {19'd0, 2'b11, 3'd0, mie_q, 7'd0};
        bus.clear_o = 32'h0000_0088;
      end
      T_REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = bus.mtvec_i;
      end
      M_STATUS: begin
        // MIE <- MPIE, MPIE <- 1, MPP <- U.
        bus.en_o    = 1'b1;
        bus.addr_o  = MSTATUS;
        bus.set_o   = {24'd0, 1'b1, 3'd0, bus.mstatus_i[7], 3'd0};
        bus.clear_o = 32'h0000_1808;
      end
      M_REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = bus.mepc_i;
      end
      default: ;
    endcase
    if (bus.en_o && (state != IDLE)) fault_o = !bus.ack_i;
  end

  assign busy_o = (state != IDLE);

endmodule
